// File: rtl/pixel_task_generator.sv
// Purpose: turns one frame configuration into a raster-ordered stream of fixed-point (x, y) pixel commands.
// Latency: the first command is valid in the cycle after the configuration is accepted, then one per cycle.
// Backpressure: a stalled command holds x, y and the counters; configuration is refused until the frame ends.
module pixel_task_generator #(
    parameter int FIX_WIDTH = 28,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_cfg_valid,
    output logic                 io_cfg_ready,
    input  logic [CNT_WIDTH-1:0] io_cfg_payload_width,
    input  logic [CNT_WIDTH-1:0] io_cfg_payload_height,
    input  logic [FIX_WIDTH-1:0] io_cfg_payload_x0,
    input  logic [FIX_WIDTH-1:0] io_cfg_payload_y0,
    input  logic [FIX_WIDTH-1:0] io_cfg_payload_xStep,
    input  logic [FIX_WIDTH-1:0] io_cfg_payload_yStep,
    output logic                 io_cmd_valid,
    input  logic                 io_cmd_ready,
    output logic [FIX_WIDTH-1:0] io_cmd_payload_x,
    output logic [FIX_WIDTH-1:0] io_cmd_payload_y,
    output logic                 io_busy,
    output logic                 io_frame_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q,     state_d;
    logic [CNT_WIDTH-1:0] width_q,     width_d;
    logic [CNT_WIDTH-1:0] height_q,    height_d;
    logic [FIX_WIDTH-1:0] x0_q,        x0_d;
    logic [FIX_WIDTH-1:0] xstep_q,     xstep_d;
    logic [FIX_WIDTH-1:0] ystep_q,     ystep_d;
    logic [CNT_WIDTH-1:0] col_q,       col_d;
    logic [CNT_WIDTH-1:0] row_q,       row_d;
    logic [FIX_WIDTH-1:0] cmd_x_q,     cmd_x_d;
    logic [FIX_WIDTH-1:0] cmd_y_q,     cmd_y_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    logic cmd_fire;
    logic last_col;
    logic last_row;

    // Counters compare against size-1 only in RUN, where width and height are known non-zero,
    // so the subtraction never underflows and a full 2^CNT_WIDTH-1 size never overflows a counter.
    assign cmd_fire = cmd_valid_q && io_cmd_ready;
    assign last_col = (col_q == (width_q - CNT_ONE));
    assign last_row = (row_q == (height_q - CNT_ONE));

    // Next-state and registered-output decode for the IDLE/RUN walker.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        x0_d        = x0_q;
        xstep_d     = xstep_q;
        ystep_d     = ystep_q;
        col_d       = col_q;
        row_d       = row_q;
        cmd_x_d     = cmd_x_q;
        cmd_y_d     = cmd_y_q;
        cmd_valid_d = cmd_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io_cfg_valid) begin
                    width_d  = io_cfg_payload_width;
                    height_d = io_cfg_payload_height;
                    x0_d     = io_cfg_payload_x0;
                    xstep_d  = io_cfg_payload_xStep;
                    ystep_d  = io_cfg_payload_yStep;
                    cmd_x_d  = io_cfg_payload_x0;
                    cmd_y_d  = io_cfg_payload_y0;
                    col_d    = '0;
                    row_d    = '0;
                    if ((io_cfg_payload_width != '0) && (io_cfg_payload_height != '0)) begin
                        state_d     = S_RUN;
                        cmd_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        // Empty frame: nothing to emit, just report completion.
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cmd_fire) begin
                    if (!last_col) begin
                        col_d   = col_q + CNT_ONE;
                        cmd_x_d = cmd_x_q + xstep_q;
                    end else if (!last_row) begin
                        col_d   = '0;
                        row_d   = row_q + CNT_ONE;
                        cmd_x_d = x0_q;
                        cmd_y_d = cmd_y_q + ystep_q;
                    end else begin
                        state_d     = S_IDLE;
                        cmd_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            x0_q        <= '0;
            xstep_q     <= '0;
            ystep_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cmd_x_q     <= '0;
            cmd_y_q     <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            x0_q        <= x0_d;
            xstep_q     <= xstep_d;
            ystep_q     <= ystep_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cmd_x_q     <= cmd_x_d;
            cmd_y_q     <= cmd_y_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign io_cfg_ready     = (state_q == S_IDLE);
    assign io_cmd_valid     = cmd_valid_q;
    assign io_cmd_payload_x = cmd_x_q;
    assign io_cmd_payload_y = cmd_y_q;
    assign io_busy          = busy_q;
    assign io_frame_done    = done_q;

endmodule

// File: doc/pixel_task_generator.md
# pixel_task_generator

- Upstream producer for the Mandelbrot pixel solver: converts one frame configuration into a raster-ordered stream of fixed-point pixel coordinates on a valid/ready command stream.
- Walks a `width` × `height` grid, stepping x per column and y per row, and emits one command per pixel.
- Signals busy while a frame is in progress and pulses done once the last pixel is accepted downstream.

## Interface
Parameters:
- FIX_WIDTH, 28, coordinate width; signed two's complement, 20 fractional bits.
- CNT_WIDTH, 10, width of the pixel/row counters and of the width/height fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- io_cfg_valid  in  1  frame configuration offered.
- io_cfg_ready  out  1  configuration accepted; high only in IDLE.
- io_cfg_payload_width  in  CNT_WIDTH  pixels per row, unsigned.
- io_cfg_payload_height  in  CNT_WIDTH  rows per frame, unsigned.
- io_cfg_payload_x0  in  FIX_WIDTH  x of the first column.
- io_cfg_payload_y0  in  FIX_WIDTH  y of the first row.
- io_cfg_payload_xStep  in  FIX_WIDTH  signed x increment per column.
- io_cfg_payload_yStep  in  FIX_WIDTH  signed y increment per row.
- io_cmd_valid  out  1  pixel command valid.
- io_cmd_ready  in  1  downstream accepts the command.
- io_cmd_payload_x  out  FIX_WIDTH  pixel x coordinate.
- io_cmd_payload_y  out  FIX_WIDTH  pixel y coordinate.
- io_busy  out  1  frame in progress (RUN state).
- io_frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, RUN.
- **IDLE → accept.** cfg_ready = 1. On cfg_valid && cfg_ready:
  - Latch width, height, x0, xStep, yStep.
  - Load cmd_x = x0, cmd_y = y0, col = 0, row = 0.
- **IDLE → RUN.** If width ≠ 0 and height ≠ 0, go to RUN.
- **IDLE, empty frame.** If width == 0 or height == 0, stay IDLE, emit no command, pulse frame_done on the next cycle.
- **RUN.** cmd_valid = 1. On each cmd handshake:
  - If col ≠ width−1: col += 1, cmd_x += xStep.
  - Else if row ≠ height−1: col = 0, row += 1, cmd_x = x0, cmd_y += yStep.
  - Else (last pixel): go to IDLE, pulse frame_done.
- **Backpressure.** While cmd_valid && !cmd_ready, x, y and the counters hold stable.
- **Configuration in RUN.** cfg_ready = 0; cfg_valid is ignored and a held cfg is accepted only after returning to IDLE.
- **Arithmetic.** FIX_WIDTH two's complement adds that wrap modulo 2^FIX_WIDTH, with no saturation. Counters are unsigned CNT_WIDTH.
- **Reset.** Takes effect immediately, including mid-frame: the frame is aborted with no done pulse.
- **Reset values.** State = IDLE; cmd_valid = 0; cmd_x = cmd_y = 0; busy = 0; frame_done = 0; cfg_ready = 1 after reset.

## Timing
- **Registered outputs.** cmd_valid, cmd_x, cmd_y, busy and frame_done are all registers; cfg_ready is decoded from state.
- **Start latency.** Configuration accepted at edge N puts the first command valid from edge N, i.e. visible in the cycle after acceptance.
- **Throughput.** One command per cycle while cmd_ready is held high; a W×H frame takes W·H cycles of valid.
- **Done.** frame_done is high for the one cycle following the edge that accepted the last pixel. busy falls on that same edge, and cfg_ready rises on that same edge.
- **Back-to-back frames.** A new configuration can be accepted in the same cycle frame_done is high, giving at least one idle cycle between frames.
- **Boundary cases:**
  - width = 1: each handshake advances the row.
  - height = 1: a single row, then done.
  - Maximum width/height of 2^CNT_WIDTH−1 must not overflow the counters.

## Test plan
- **2×2 frame.** Config x0 = 0xFE00000 (−2.0), y0 = 0xFF00000 (−1.0), xStep = yStep = 0x0080000 (0.5), ready tied high. Required:
  - Commands (x, y) in order: (−2.0, −1.0), (−1.5, −1.0), (−2.0, −0.5), (−1.5, −0.5) on 4 consecutive cycles.
  - frame_done pulses once, 1 cycle after the 4th handshake.
- **Backpressure.** 3×1 frame, ready toggling 1/0 every cycle → exactly 3 handshakes, payload stable across every stalled cycle, done pulses after the 3rd.
- **Empty frame.** width = 0, height = 5 → no cmd_valid ever, frame_done pulses once the cycle after acceptance, busy stays 0.
- **Wrap.** x0 = 0x7FFFFFF, xStep = 1, 2×1 frame → second x = 0x8000000.
- **Configuration during RUN.** cfg_valid held during a 4×4 frame → cfg_ready = 0 throughout. The second frame starts after done, and exactly 16 commands come out of the first frame.
- **Reset mid-frame.** Assert reset after 5 of 16 pixels → cmd_valid, busy and x/y go to 0 immediately, no done pulse. After release, a new frame runs cleanly.
